// File: rtl/uart_pkg.sv
// Shared types and constants for the USART receive path: FSM states, character
// size / parity mode codes and the per-character FIFO entry layout.
package uart_pkg;

   typedef enum logic [2:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_PARITY,
      RX_STOP,
      RX_WAIT_IDLE
   } rx_state_e;

   localparam logic [2:0] CS_5 = 3'b000;
   localparam logic [2:0] CS_6 = 3'b001;
   localparam logic [2:0] CS_7 = 3'b010;
   localparam logic [2:0] CS_8 = 3'b011;
   localparam logic [2:0] CS_9 = 3'b111;

   localparam logic [1:0] UPM_NONE = 2'b00;
   localparam logic [1:0] UPM_EVEN = 2'b10;
   localparam logic [1:0] UPM_ODD  = 2'b11;

   typedef struct packed {
      logic       dor;
      logic       pe;
      logic       fe;
      logic [8:0] data;
   } rx_entry_t;

   // Reserved character-size codes fall back to 8 data bits.
   function automatic logic [3:0] char_bits(input logic [2:0] code);
      case (code)
         CS_5:    return 4'd5;
         CS_6:    return 4'd6;
         CS_7:    return 4'd7;
         CS_9:    return 4'd9;
         default: return 4'd8;
      endcase
   endfunction

endpackage

// File: rtl/uart_rx_sync_fifo.sv
// Show-ahead receive FIFO of rx_entry_t; the head is presented combinationally
// from storage and reads as all-zero while the FIFO is empty.
module uart_rx_sync_fifo
   import uart_pkg::*;
#(
   parameter  int DEPTH = 4,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic        org_clk,
   input  logic        rst,
   input  logic        push,
   input  rx_entry_t   push_data,
   input  logic        pop,
   output rx_entry_t   head,
   output logic        full,
   output logic        empty,
   output logic [AW:0] level
);

   rx_entry_t   mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic          do_push;
   logic          do_pop;

   assign full  = (count == (AW + 1)'(DEPTH));
   assign empty = (count == '0);
   assign level = count;

   // A pop in the same cycle frees the slot, so a push against a full FIFO still lands.
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   assign head = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge org_clk) begin
      if (do_push)
         mem[wr_ptr] <= push_data;
   end

   always_ff @(posedge org_clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push)
            wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)
            rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/uart_rx_fifo.sv
// Oversampling USART receiver (5-9 data bits, none/even/odd parity) feeding a
// status-carrying receive FIFO. Define UART_RX_MAJORITY_EN for 2-of-3 bit voting.
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter  int OVS   = 16,
   parameter  int DEPTH = 4,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic        org_clk,
   input  logic        rst,
   input  logic        baud_tick,
   input  logic        rxen,
   input  logic        sin,
   input  logic        u2xn,
   input  logic [2:0]  char_size,
   input  logic [1:0]  upm,
   input  logic        rd_en,
   output logic [8:0]  rd_data,
   output logic        rd_fe,
   output logic        rd_pe,
   output logic        rd_dor,
   output logic        rx_avail,
   output logic [AW:0] rx_level
);

   localparam int CW = $clog2(OVS);
`ifdef UART_RX_MAJORITY_EN
   localparam int MAJ = 1;
`else
   localparam int MAJ = 0;
`endif

   // Start is resolved at MID (MID+1 when voting, once the trailing sample is in);
   // every later bit is resolved exactly one bit period after that.
   localparam logic [CW-1:0] LAST_FULL  = CW'(OVS - 1);
   localparam logic [CW-1:0] LAST_HALF  = CW'(OVS / 2 - 1);
   localparam logic [CW-1:0] START_FULL = CW'(OVS / 2 - 2 + MAJ);
   localparam logic [CW-1:0] START_HALF = CW'((OVS / 2) / 2 - 2 + MAJ);

   rx_state_e      state;
   logic [CW-1:0]  tick_cnt;
   logic [3:0]     bit_cnt;
   logic [8:0]     data_reg;
   logic           pe_reg;
   logic [3:0]     n_bits;
   logic           par_en;
   logic           par_odd;
   logic           half;
   logic           dor_pend;

   logic           bit_val;
   logic           at_last;
   logic           at_start;
   logic           push;
   logic           fifo_full;
   logic           fifo_empty;
   rx_entry_t      push_entry;
   rx_entry_t      head;

`ifdef UART_RX_MAJORITY_EN
   logic [1:0] hist;

   always_ff @(posedge org_clk or posedge rst) begin
      if (rst)
         hist <= 2'b11;
      else if (baud_tick)
         hist <= {hist[0], sin};
   end

   assign bit_val = (hist[1] & hist[0]) | (hist[1] & sin) | (hist[0] & sin);
`else
   assign bit_val = sin;
`endif

   assign at_last  = (tick_cnt == (half ? LAST_HALF : LAST_FULL));
   assign at_start = (tick_cnt == (half ? START_HALF : START_FULL));

   always_ff @(posedge org_clk or posedge rst) begin
      if (rst) begin
         state    <= RX_IDLE;
         tick_cnt <= '0;
         bit_cnt  <= '0;
         data_reg <= '0;
         pe_reg   <= 1'b0;
         n_bits   <= 4'd8;
         par_en   <= 1'b0;
         par_odd  <= 1'b0;
         half     <= 1'b0;
      end else if (!rxen) begin
         state    <= RX_IDLE;
         tick_cnt <= '0;
         bit_cnt  <= '0;
      end else begin
         case (state)
            RX_IDLE: begin
               if (baud_tick && !sin) begin
                  state    <= RX_START;
                  tick_cnt <= '0;
                  bit_cnt  <= '0;
                  data_reg <= '0;
                  pe_reg   <= 1'b0;
                  n_bits   <= char_bits(char_size);
                  par_en   <= upm[1];
                  par_odd  <= upm[0];
                  half     <= u2xn;
               end
            end
            RX_START: begin
               if (baud_tick) begin
                  if (at_start) begin
                     tick_cnt <= '0;
                     state    <= bit_val ? RX_IDLE : RX_DATA;
                  end else begin
                     tick_cnt <= tick_cnt + 1'b1;
                  end
               end
            end
            RX_DATA: begin
               if (baud_tick) begin
                  if (at_last) begin
                     tick_cnt          <= '0;
                     data_reg[bit_cnt] <= bit_val;
                     if (bit_cnt == n_bits - 4'd1) begin
                        bit_cnt <= '0;
                        state   <= par_en ? RX_PARITY : RX_STOP;
                     end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                     end
                  end else begin
                     tick_cnt <= tick_cnt + 1'b1;
                  end
               end
            end
            RX_PARITY: begin
               if (baud_tick) begin
                  if (at_last) begin
                     tick_cnt <= '0;
                     pe_reg   <= ((^data_reg) ^ bit_val) != par_odd;
                     state    <= RX_STOP;
                  end else begin
                     tick_cnt <= tick_cnt + 1'b1;
                  end
               end
            end
            RX_STOP: begin
               if (baud_tick) begin
                  if (at_last) begin
                     tick_cnt <= '0;
                     state    <= bit_val ? RX_IDLE : RX_WAIT_IDLE;
                  end else begin
                     tick_cnt <= tick_cnt + 1'b1;
                  end
               end
            end
            RX_WAIT_IDLE: begin
               if (sin)
                  state <= RX_IDLE;
            end
            default: state <= RX_IDLE;
         endcase
      end
   end

   // The character is pushed on the stop-sample tick itself so it shows up one cycle later.
   assign push = rxen & baud_tick & (state == RX_STOP) & at_last;

   always_comb begin
      push_entry      = '0;
      push_entry.dor  = dor_pend;
      push_entry.pe   = pe_reg;
      push_entry.fe   = ~bit_val;
      push_entry.data = data_reg;
   end

   always_ff @(posedge org_clk or posedge rst) begin
      if (rst)
         dor_pend <= 1'b0;
      else if (push)
         dor_pend <= fifo_full & ~rd_en;
   end

   uart_rx_sync_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .org_clk   (org_clk),
      .rst       (rst),
      .push      (push),
      .push_data (push_entry),
      .pop       (rd_en),
      .head      (head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .level     (rx_level)
   );

   assign rd_data  = head.data;
   assign rd_fe    = head.fe;
   assign rd_pe    = head.pe;
   assign rd_dor   = head.dor;
   assign rx_avail = ~fifo_empty;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo (OVS=16, DEPTH=4): frames are driven bit by
// bit against baud ticks and the FIFO head/status is compared to fixed values.
module tb_uart_rx_fifo;

   logic       org_clk = 1'b0;
   logic       rst;
   logic       baud_tick;
   logic       rxen;
   logic       sin;
   logic       u2xn;
   logic [2:0] char_size;
   logic [1:0] upm;
   logic       rd_en;
   logic [8:0] rd_data;
   logic       rd_fe;
   logic       rd_pe;
   logic       rd_dor;
   logic       rx_avail;
   logic [2:0] rx_level;

   int n_tests = 0;
   int n_fail  = 0;
   int div     = 1;
   int phase   = 0;
   int spb     = 16;

   uart_rx_fifo #(.OVS(16), .DEPTH(4)) dut (
      .org_clk   (org_clk),
      .rst       (rst),
      .baud_tick (baud_tick),
      .rxen      (rxen),
      .sin       (sin),
      .u2xn      (u2xn),
      .char_size (char_size),
      .upm       (upm),
      .rd_en     (rd_en),
      .rd_data   (rd_data),
      .rd_fe     (rd_fe),
      .rd_pe     (rd_pe),
      .rd_dor    (rd_dor),
      .rx_avail  (rx_avail),
      .rx_level  (rx_level)
   );

   always #5 org_clk = ~org_clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end else begin
         $display("[TB] ok   %s = 0x%0h", tag, got);
      end
   endtask

   // One clock; baud_tick for the following cycle is updated just after the edge.
   task automatic cyc();
      @(posedge org_clk);
      #1;
      phase     = (phase + 1) % div;
      baud_tick = (phase == 0);
   endtask

   task automatic send_level(input logic v, input int n);
      int cnt;
      cnt = 0;
      sin = v;
      while (cnt < n) begin
         if (baud_tick)
            cnt++;
         cyc();
      end
   endtask

   task automatic send_frame(input logic [8:0] d, input int nbits, input bit par,
                             input logic pbit, input logic stopv, input int stop_len);
      send_level(1'b0, spb);
      for (int i = 0; i < nbits; i++)
         send_level(d[i], spb);
      if (par)
         send_level(pbit, spb);
      send_level(stopv, spb * stop_len);
      send_level(1'b1, 4);
   endtask

   task automatic pop();
      rd_en = 1'b1;
      cyc();
      rd_en = 1'b0;
   endtask

   task automatic check_head(input string tag, input logic [8:0] d, input logic fe,
                             input logic pe, input logic dor);
      check({tag, " avail"}, 32'(rx_avail), 32'd1);
      check({tag, " data"},  32'(rd_data),  32'(d));
      check({tag, " fe"},    32'(rd_fe),    32'(fe));
      check({tag, " pe"},    32'(rd_pe),    32'(pe));
      check({tag, " dor"},   32'(rd_dor),   32'(dor));
   endtask

   initial begin
      rst       = 1'b1;
      baud_tick = 1'b1;
      rxen      = 1'b1;
      sin       = 1'b1;
      u2xn      = 1'b0;
      char_size = 3'b011;
      upm       = 2'b00;
      rd_en     = 1'b0;
      repeat (3) cyc();
      check("reset avail", 32'(rx_avail), 32'd0);
      check("reset level", 32'(rx_level), 32'd0);
      check("reset data",  32'(rd_data),  32'd0);
      check("reset flags", 32'({rd_fe, rd_pe, rd_dor}), 32'd0);
      rst = 1'b0;
      repeat (3) cyc();

      // 8N1 0xA5
      send_frame(9'h0A5, 8, 1'b0, 1'b0, 1'b1, 1);
      check_head("8N1 A5", 9'h0A5, 1'b0, 1'b0, 1'b0);
      pop();
      check("8N1 pop avail", 32'(rx_avail), 32'd0);
      check("8N1 pop level", 32'(rx_level), 32'd0);
      pop();
      check("empty pop level", 32'(rx_level), 32'd0);

      // 9-bit odd parity, good then bad parity bit
      char_size = 3'b111;
      upm       = 2'b11;
      send_frame(9'h1C3, 9, 1'b1, 1'b0, 1'b1, 1);
      check_head("9O1 good", 9'h1C3, 1'b0, 1'b0, 1'b0);
      pop();
      send_frame(9'h1C3, 9, 1'b1, 1'b1, 1'b1, 1);
      check_head("9O1 bad", 9'h1C3, 1'b0, 1'b1, 1'b0);
      pop();

      // 5N1 with a 3-bit-time break as stop
      char_size = 3'b000;
      upm       = 2'b00;
      send_frame(9'h015, 5, 1'b0, 1'b0, 1'b0, 3);
      send_level(1'b1, 2 * spb);
      check("break level", 32'(rx_level), 32'd1);
      check_head("5N1 break", 9'h015, 1'b1, 1'b0, 1'b0);
      pop();

      // Overrun: six characters into a 4-deep FIFO
      char_size = 3'b011;
      for (int i = 1; i <= 6; i++) begin
         send_frame(9'(i), 8, 1'b0, 1'b0, 1'b1, 1);
         if (i == 4)
            check("ovr level@4", 32'(rx_level), 32'd4);
      end
      check("ovr level@6", 32'(rx_level), 32'd4);
      check_head("ovr head1", 9'h001, 1'b0, 1'b0, 1'b0);
      pop();
      check("ovr level pop", 32'(rx_level), 32'd3);
      send_frame(9'h007, 8, 1'b0, 1'b0, 1'b1, 1);
      check("ovr level@7", 32'(rx_level), 32'd4);
      check_head("ovr head2", 9'h002, 1'b0, 1'b0, 1'b0);
      pop();
      check_head("ovr head3", 9'h003, 1'b0, 1'b0, 1'b0);
      pop();
      check_head("ovr head4", 9'h004, 1'b0, 1'b0, 1'b0);
      pop();
      check_head("ovr tail7", 9'h007, 1'b0, 1'b0, 1'b1);
      pop();
      check("ovr drained", 32'(rx_level), 32'd0);

      // Short low pulse on an idle line is rejected at start validation
      send_level(1'b0, 4);
      send_level(1'b1, 2 * spb);
      check("glitch start", 32'(rx_level), 32'd0);

      // rxen dropped during data bit 3: partial character discarded
      send_level(1'b0, spb);
      send_level(1'b0, spb);
      send_level(1'b1, spb);
      send_level(1'b0, spb);
      send_level(1'b1, 4);
      rxen = 1'b0;
      send_level(1'b1, spb - 4);
      send_level(1'b0, 4 * spb);
      send_level(1'b1, 2 * spb);
      rxen = 1'b1;
      send_level(1'b1, 2 * spb);
      check("rxen abort level", 32'(rx_level), 32'd0);
      send_frame(9'h05A, 8, 1'b0, 1'b0, 1'b1, 1);
      check_head("after abort", 9'h05A, 1'b0, 1'b0, 1'b0);
      pop();

      // Double speed 8E1 with a baud tick every third cycle
      u2xn = 1'b1;
      upm  = 2'b10;
      spb  = 8;
      div  = 3;
      send_frame(9'h03C, 8, 1'b1, 1'b0, 1'b1, 1);
      check_head("u2x 8E1", 9'h03C, 1'b0, 1'b0, 1'b0);
      pop();

      // One-tick low glitch at the middle sample of data bit 2
      send_level(1'b0, spb);
      send_level(1'b0, spb);
      send_level(1'b0, spb);
      send_level(1'b1, 3);
      send_level(1'b0, 1);
      send_level(1'b1, 4);
      for (int i = 3; i < 8; i++)
         send_level(((9'h03C >> i) & 9'h1) != 9'h0, spb);
      send_level(1'b0, spb);
      send_level(1'b1, spb + 4);
`ifdef UART_RX_MAJORITY_EN
      check_head("u2x glitch", 9'h03C, 1'b0, 1'b0, 1'b0);
`else
      check_head("u2x glitch", 9'h038, 1'b0, 1'b1, 1'b0);
`endif
      pop();
      check("final level", 32'(rx_level), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
